sdram_axi_memtest: RTL and testbench
====================================

Name: sdram_axi_memtest

Overview:
- AXI4 master traffic generator that sits directly upstream of the sdram_axi controller and drives its inport_* AXI port.
- Write phase: fills a configurable SDRAM region with an address-derived pattern using fixed-length INCR bursts.
- Read phase: reads the same region back, compares every beat and reports pass/fail, error count and first failing address.
- Used for board bring-up and as a regression stimulus source for the SDRAM path.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first burst; must be 4-byte aligned.
- NUM_BURSTS, 16, number of bursts per phase; range 1..65535.
- BURST_LEN, 8, beats per burst; range 1..256; awlen/arlen = BURST_LEN-1.
- SEED, 32'hA5A5_A5A5, XOR mask for the data pattern.
- AXI_ID, 4'h0, value driven on awid/arid.

Ports:
- clk_i  in  1  system clock, shared with sdram_axi
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  single-cycle start pulse
- busy_o  out  1  high from accepted start until done
- done_o  out  1  high after completion; held until next accepted start
- pass_o  out  1  valid when done_o=1; 1 means err_count_o==0
- err_count_o  out  16  count of errors, saturating at 16'hFFFF
- first_err_addr_o  out  32  byte address of the first error
- outport_awvalid_o / awready_i  out/in  1  write address handshake
- outport_awaddr_o  out  32  burst base address
- outport_awid_o  out  4  AXI_ID
- outport_awlen_o  out  8  BURST_LEN-1
- outport_awburst_o  out  2  2'b01 (INCR)
- outport_wvalid_o / wready_i  out/in  1  write data handshake
- outport_wdata_o  out  32  pattern word
- outport_wstrb_o  out  4  4'hF
- outport_wlast_o  out  1  high on beat BURST_LEN-1
- outport_bvalid_i / bready_o  in/out  1  write response handshake
- outport_bresp_i  in  2  write response
- outport_bid_i  in  4  ignored
- outport_arvalid_o / arready_i  out/in  1  read address handshake
- outport_araddr_o  out  32  burst base address
- outport_arid_o  out  4  AXI_ID
- outport_arlen_o  out  8  BURST_LEN-1
- outport_arburst_o  out  2  2'b01 (INCR)
- outport_rvalid_i / rready_o  in/out  1  read data handshake
- outport_rdata_i  in  32  read data
- outport_rresp_i  in  2  read response
- outport_rid_i  in  4  ignored
- outport_rlast_i  in  1  last read beat

Behaviour:
- Reset: all outputs are 0, except the constant fields (awid, arid, awlen, arlen, awburst, arburst, wstrb). FSM state is IDLE. A reset mid-operation aborts immediately and issues no further AXI transfers.
- Addressing: burst k base = BASE_ADDR + k*BURST_LEN*4. Beat j address = base + 4*j. All address arithmetic is 32-bit and wraps modulo 2^32.
- Pattern: data(beat address) = beat address ^ SEED.
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: start_i=1 clears err_count_o, first_err_addr_o, pass_o and done_o, sets busy_o, resets the burst counter, then goes to WR_ADDR. start_i is ignored in every other state except DONE.
- WR_ADDR: awvalid=1 with awaddr stable until awready=1. On that handshake, go to WR_DATA.
- WR_DATA: wvalid=1. wdata and wlast stay stable while wvalid=1 and wready=0. The beat counter advances on each wvalid&wready. After the wlast beat is accepted, go to WR_RESP.
- WR_RESP: bready=1. On bvalid, bresp!=2'b00 counts as one error at the burst base address. If more bursts remain, the burst counter increments and the FSM goes to WR_ADDR. Otherwise the counter resets and the FSM goes to RD_ADDR.
- AW and W are never issued concurrently; there is at most one outstanding transaction.
- RD_ADDR: arvalid=1 held until arready=1, then go to RD_DATA.
- RD_DATA: rready=1. Each rvalid beat counts one error if any of the following holds:
  - rdata differs from the expected pattern;
  - rresp != 0;
  - rlast disagrees with (beat==BURST_LEN-1).
- Multiple error causes on the same beat count as a single error. The beat count alone decides when a burst ends. After the last burst, go to DONE.
- Error capture:
  - first_err_addr_o is loaded only when err_count_o==0 at the moment of the error.
  - err_count_o saturates at 16'hFFFF and never wraps.
- DONE: busy_o=0, done_o=1, pass_o=(err_count_o==0). Outputs hold. start_i=1 restarts exactly as from IDLE.
- Latency: the first AW is asserted on the cycle after start_i is sampled. done_o rises on the cycle after the final read beat is accepted.

Test Plan:
- Reset: assert rst_i mid-cycle without a clock edge. All handshake outputs, busy_o, done_o, pass_o and err_count_o go to 0 immediately.
- Clean run, ideal slave, NUM_BURSTS=2, BURST_LEN=8:
  - AW at 0x00 then 0x20, awlen=7.
  - First wdata = 0xA5A5A5A5; beat at 0x04 = 0xA5A5A5A1.
  - wlast on beats 7 and 15.
  - Two AR transfers, then done_o=1, pass_o=1, err_count_o=0.
- Corrupt read beat at 0x2C (flip bit 0): err_count_o=1, first_err_addr_o=0x0000002C, pass_o=0.
- Backpressure: hold awready=0 for 5 cycles and toggle wready every cycle. awaddr, wdata and wlast stay stable while valid&!ready. Beat order is unchanged and pass_o=1.
- Burst 0 returns bresp=2'b10 and rresp is clean everywhere: err_count_o=1, first_err_addr_o=0x00000000. Also, rlast early on beat 5 of burst 1: err_count_o=2.
- start_i pulsed while busy_o=1: no effect. rst_i asserted during WR_DATA: outputs clear. A new start_i then completes with pass_o=1.

Source files
------------

// File: rtl/sdram_axi_memtest_if.sv
// AXI4 bus between the memtest traffic generator (master) and the sdram_axi
// inport (slave).
interface sdram_axi_memtest_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;

  modport master (
    output awvalid, awaddr, awid, awlen, awburst,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    output arvalid, araddr, arid, arlen, arburst,
    output rready,
    input  awready, wready, bvalid, bresp, bid,
    input  arready, rvalid, rdata, rresp, rid, rlast
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awburst,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, araddr, arid, arlen, arburst,
    input  rready,
    output awready, wready, bvalid, bresp, bid,
    output arready, rvalid, rdata, rresp, rid, rlast
  );
endinterface

// File: rtl/sdram_axi_memtest.sv
// SDRAM memtest: writes addr^SEED over a region in INCR bursts, reads it back,
// counts errors and records the first failing byte address.
//   state    | meaning
//   IDLE     | waiting for start_i
//   WR_ADDR  | AW issued, waiting for awready
//   WR_DATA  | streaming write beats
//   WR_RESP  | waiting for B response
//   RD_ADDR  | AR issued, waiting for arready
//   RD_DATA  | checking read beats
//   DONE     | result held, start_i restarts
module sdram_axi_memtest #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned NUM_BURSTS = 16,
  parameter int unsigned BURST_LEN  = 8,
  parameter logic [31:0] SEED       = 32'hA5A5_A5A5,
  parameter logic [3:0]  AXI_ID     = 4'h0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       pass_o,
  output logic [15:0]                err_count_o,
  output logic [31:0]                first_err_addr_o,
  sdram_axi_memtest_if.master        outport
);

  localparam logic [7:0]  LEN_M1      = 8'(BURST_LEN - 1);
  localparam logic [15:0] BURSTS_M1   = 16'(NUM_BURSTS - 1);
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 4);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } state_t;

  state_t      r_state;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [15:0] r_err_count;
  logic [31:0] r_first_err;
  logic [31:0] r_burst_addr;
  logic [31:0] r_beat_addr;
  logic [7:0]  r_beat_cnt;
  logic [15:0] r_burst_cnt;
  logic        r_awvalid;
  logic        r_wvalid;
  logic [31:0] r_wdata;
  logic        r_wlast;
  logic        r_bready;
  logic        r_arvalid;
  logic        r_rready;

  logic        w_last_beat;
  logic        w_last_burst;
  logic [31:0] w_next_beat_addr;
  logic [31:0] w_next_burst_addr;
  logic        w_rd_bad;
  logic        w_err_hit;
  logic [31:0] w_err_addr;
  logic        w_unused_ids;

  // Beat and burst counters count down; zero marks the final one.
  assign w_last_beat       = (r_beat_cnt == 8'd0);
  assign w_last_burst      = (r_burst_cnt == 16'd0);
  assign w_next_beat_addr  = r_beat_addr + 32'd4;
  assign w_next_burst_addr = r_burst_addr + BURST_BYTES;

  assign w_rd_bad = (outport.rdata != (r_beat_addr ^ SEED)) ||
                    (outport.rresp != 2'b00) ||
                    (outport.rlast != w_last_beat);

  assign w_err_hit = ((r_state == ST_WR_RESP) && outport.bvalid && (outport.bresp != 2'b00)) ||
                     ((r_state == ST_RD_DATA) && outport.rvalid && w_rd_bad);
  assign w_err_addr = (r_state == ST_WR_RESP) ? r_burst_addr : r_beat_addr;

  assign w_unused_ids = ^{outport.bid, outport.rid};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_count  <= 16'd0;
      r_first_err  <= 32'd0;
      r_burst_addr <= 32'd0;
      r_beat_addr  <= 32'd0;
      r_beat_cnt   <= 8'd0;
      r_burst_cnt  <= 16'd0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_wdata      <= 32'd0;
      r_wlast      <= 1'b0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= 16'd0;
            r_first_err  <= 32'd0;
            r_burst_addr <= BASE_ADDR;
            r_burst_cnt  <= BURSTS_M1;
            r_awvalid    <= 1'b1;
            r_state      <= ST_WR_ADDR;
          end
        end
        ST_WR_ADDR: begin
          if (outport.awready) begin
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b1;
            r_beat_addr <= r_burst_addr;
            r_beat_cnt  <= LEN_M1;
            r_wdata     <= r_burst_addr ^ SEED;
            r_wlast     <= (LEN_M1 == 8'd0);
            r_state     <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (outport.wready) begin
            if (w_last_beat) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_wdata  <= 32'd0;
              r_bready <= 1'b1;
              r_state  <= ST_WR_RESP;
            end else begin
              r_beat_cnt  <= r_beat_cnt - 8'd1;
              r_beat_addr <= w_next_beat_addr;
              r_wdata     <= w_next_beat_addr ^ SEED;
              r_wlast     <= (r_beat_cnt == 8'd1);
            end
          end
        end
        ST_WR_RESP: begin
          if (outport.bvalid) begin
            r_bready <= 1'b0;
            if (w_last_burst) begin
              r_burst_cnt  <= BURSTS_M1;
              r_burst_addr <= BASE_ADDR;
              r_arvalid    <= 1'b1;
              r_state      <= ST_RD_ADDR;
            end else begin
              r_burst_cnt  <= r_burst_cnt - 16'd1;
              r_burst_addr <= w_next_burst_addr;
              r_awvalid    <= 1'b1;
              r_state      <= ST_WR_ADDR;
            end
          end
        end
        ST_RD_ADDR: begin
          if (outport.arready) begin
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b1;
            r_beat_addr <= r_burst_addr;
            r_beat_cnt  <= LEN_M1;
            r_state     <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (outport.rvalid) begin
            if (w_last_beat) begin
              r_rready <= 1'b0;
              if (w_last_burst) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                // Final beat may itself be in error, so fold it in here.
                r_pass  <= (r_err_count == 16'd0) && !w_err_hit;
                r_state <= ST_DONE;
              end else begin
                r_burst_cnt  <= r_burst_cnt - 16'd1;
                r_burst_addr <= w_next_burst_addr;
                r_arvalid    <= 1'b1;
                r_state      <= ST_RD_ADDR;
              end
            end else begin
              r_beat_cnt  <= r_beat_cnt - 8'd1;
              r_beat_addr <= w_next_beat_addr;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_err_hit) begin
        if (r_err_count == 16'd0) r_first_err <= w_err_addr;
        if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign pass_o           = r_pass;
  assign err_count_o      = r_err_count;
  assign first_err_addr_o = r_first_err;

  assign outport.awvalid = r_awvalid;
  assign outport.awaddr  = r_burst_addr;
  assign outport.awid    = AXI_ID;
  assign outport.awlen   = LEN_M1;
  assign outport.awburst = 2'b01;
  assign outport.wvalid  = r_wvalid;
  assign outport.wdata   = r_wdata;
  assign outport.wstrb   = 4'hF;
  assign outport.wlast   = r_wlast;
  assign outport.bready  = r_bready;
  assign outport.arvalid = r_arvalid;
  assign outport.araddr  = r_burst_addr;
  assign outport.arid    = AXI_ID;
  assign outport.arlen   = LEN_M1;
  assign outport.arburst = 2'b01;
  assign outport.rready  = r_rready;

endmodule

// File: tb/tb_sdram_axi_memtest.sv
// Directed bench for sdram_axi_memtest: a cycle-level AXI slave driven from the
// main sequence, with error injection and backpressure knobs.
module tb_sdram_axi_memtest;

  localparam logic [31:0] SEED = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [31:0] first_err;

  sdram_axi_memtest_if axi ();

  sdram_axi_memtest #(
    .BASE_ADDR  (32'h0000_0000),
    .NUM_BURSTS (2),
    .BURST_LEN  (8),
    .SEED       (SEED),
    .AXI_ID     (4'h0)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .busy_o           (busy),
    .done_o           (done),
    .pass_o           (pass),
    .err_count_o      (err_count),
    .first_err_addr_o (first_err),
    .outport          (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // slave configuration
  int          aw_stall;
  bit          w_toggle;
  int          bad_b_burst;
  bit          flip_en;
  logic [31:0] flip_addr;
  int          early_rlast_burst;
  int          start_pulse_cyc;

  // observations
  logic [31:0] aw_log [0:7];
  logic [7:0]  awlen_log;
  logic [31:0] w_log [0:31];
  logic [31:0] wlast_mask;
  int n_aw, n_w, n_ar, n_r;
  int stab_err, aw_stall_cnt, w_stall_cnt;
  int last_r_cyc, done_cyc;
  bit fin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cfg_default();
    aw_stall = 0;
    w_toggle = 0;
    bad_b_burst = -1;
    flip_en = 0;
    flip_addr = 32'd0;
    early_rlast_burst = -1;
    start_pulse_cyc = -1;
  endtask

  task automatic clear_inputs();
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0; axi.bid = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0; axi.rid = 0;
    axi.rlast = 0;
  endtask

  // Called right after start=1 is set on a falling edge.
  task automatic run_slave(input int budget, input int stop_after_w, output bit finished);
    int aw_wait, wr_burst, rd_beat, rd_burst;
    bit b_pend, rd_act, prev_aw_stall, prev_w_stall;
    logic [31:0] rd_base, prev_awaddr, prev_wdata, beat_a;
    logic prev_wlast;
    n_aw = 0; n_w = 0; n_ar = 0; n_r = 0;
    stab_err = 0; aw_stall_cnt = 0; w_stall_cnt = 0;
    last_r_cyc = -100; done_cyc = -1;
    wlast_mask = 32'd0; awlen_log = 8'd0;
    for (int i = 0; i < 32; i++) w_log[i] = 32'hDEAD_BEEF;
    for (int i = 0; i < 8; i++) aw_log[i] = 32'hDEAD_BEEF;
    aw_wait = aw_stall; wr_burst = 0; rd_beat = 0; rd_burst = 0;
    b_pend = 0; rd_act = 0; prev_aw_stall = 0; prev_w_stall = 0;
    rd_base = 0; prev_awaddr = 0; prev_wdata = 0; prev_wlast = 0;
    finished = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      start = (cyc == start_pulse_cyc);
      if (cyc == 0) begin
        clear_inputs();
        chk("aw_latency", {31'd0, axi.awvalid}, 32'd1);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        finished = 1;
        break;
      end
      if (stop_after_w > 0 && n_w >= stop_after_w) begin
        finished = 1;
        break;
      end
      if (prev_aw_stall && (axi.awvalid !== 1'b1 || axi.awaddr !== prev_awaddr)) stab_err++;
      if (prev_w_stall && (axi.wvalid !== 1'b1 || axi.wdata !== prev_wdata ||
                           axi.wlast !== prev_wlast)) stab_err++;

      if (axi.awvalid === 1'b1) begin
        if (aw_wait > 0) begin axi.awready = 0; aw_wait--; end
        else axi.awready = 1;
      end else axi.awready = 0;
      axi.wready  = w_toggle ? ~axi.wready : 1'b1;
      axi.bvalid  = b_pend;
      axi.bresp   = (b_pend && wr_burst == bad_b_burst) ? 2'b10 : 2'b00;
      axi.arready = 1;
      beat_a      = rd_base + 32'(rd_beat) * 32'd4;
      axi.rvalid  = rd_act;
      axi.rdata   = rd_act ? (beat_a ^ SEED ^ ((flip_en && beat_a == flip_addr) ? 32'd1 : 32'd0)) : 32'd0;
      axi.rlast   = rd_act && (rd_beat == 7 || (rd_burst == early_rlast_burst && rd_beat == 5));
      axi.rresp   = 2'b00;

      prev_aw_stall = axi.awvalid && !axi.awready;
      prev_awaddr   = axi.awaddr;
      prev_w_stall  = axi.wvalid && !axi.wready;
      prev_wdata    = axi.wdata;
      prev_wlast    = axi.wlast;
      if (prev_aw_stall) aw_stall_cnt++;
      if (prev_w_stall) w_stall_cnt++;

      if (axi.awvalid && axi.awready) begin
        if (n_aw < 8) aw_log[n_aw] = axi.awaddr;
        awlen_log = axi.awlen;
        n_aw++;
        aw_wait = aw_stall;
      end
      if (axi.bvalid && axi.bready) begin
        b_pend = 0;
        wr_burst++;
      end
      if (axi.wvalid && axi.wready) begin
        if (n_w < 32) begin
          w_log[n_w] = axi.wdata;
          wlast_mask[n_w] = axi.wlast;
        end
        n_w++;
        if (axi.wlast) b_pend = 1;
      end
      if (axi.rvalid && axi.rready) begin
        n_r++;
        last_r_cyc = cyc;
        rd_beat++;
        if (rd_beat == 8) begin rd_act = 0; rd_burst++; end
      end
      if (axi.arvalid && axi.arready) begin
        n_ar++;
        rd_base = axi.araddr;
        rd_beat = 0;
        rd_act = 1;
      end
    end
  endtask

  function automatic int count_bad_wdata();
    int bad = 0;
    for (int i = 0; i < 16; i++)
      if (w_log[i] !== ((32'(i) * 32'd4) ^ SEED)) bad++;
    return bad;
  endfunction

  task automatic go(input int stop_after_w);
    @(negedge clk);
    chk("idle_no_aw", {31'd0, axi.awvalid}, 32'd0);
    start = 1;
    run_slave(600, stop_after_w, fin);
    chk("run_finished", {31'd0, fin}, 32'd1);
  endtask

  initial begin
    rst = 1; start = 0;
    clear_inputs();
    cfg_default();
    repeat (3) @(negedge clk);
    chk("rst_awvalid", {31'd0, axi.awvalid}, 32'd0);
    chk("rst_wvalid",  {31'd0, axi.wvalid},  32'd0);
    chk("rst_busy",    {31'd0, busy},        32'd0);
    chk("rst_done",    {31'd0, done},        32'd0);
    chk("rst_err",     {16'd0, err_count},   32'd0);
    chk("rst_awlen",   {24'd0, axi.awlen},   32'd7);
    chk("rst_wstrb",   {28'd0, axi.wstrb},   32'hF);
    chk("rst_arburst", {30'd0, axi.arburst}, 32'd1);
    rst = 0;
    @(negedge clk);

    // clean run
    go(0);
    chk("clean_aw0",     aw_log[0], 32'h0000_0000);
    chk("clean_aw1",     aw_log[1], 32'h0000_0020);
    chk("clean_awlen",   {24'd0, awlen_log}, 32'd7);
    chk("clean_wdata0",  w_log[0], 32'hA5A5_A5A5);
    chk("clean_wdata1",  w_log[1], 32'hA5A5_A5A1);
    chk("clean_wlast",   wlast_mask, 32'h0000_8080);
    chk("clean_nw",      n_w, 16);
    chk("clean_wbad",    count_bad_wdata(), 0);
    chk("clean_nar",     n_ar, 2);
    chk("clean_nr",      n_r, 16);
    chk("clean_done_lat", done_cyc - last_r_cyc, 1);
    chk("clean_done",    {31'd0, done}, 32'd1);
    chk("clean_busy",    {31'd0, busy}, 32'd0);
    chk("clean_pass",    {31'd0, pass}, 32'd1);
    chk("clean_err",     {16'd0, err_count}, 32'd0);

    // corrupted read beat at 0x2C
    cfg_default();
    flip_en = 1; flip_addr = 32'h0000_002C;
    go(0);
    chk("flip_err",   {16'd0, err_count}, 32'd1);
    chk("flip_first", first_err, 32'h0000_002C);
    chk("flip_pass",  {31'd0, pass}, 32'd0);
    chk("flip_done",  {31'd0, done}, 32'd1);

    // asynchronous reset between clock edges
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_done",  {31'd0, done}, 32'd0);
    chk("arst_err",   {16'd0, err_count}, 32'd0);
    chk("arst_first", first_err, 32'd0);
    chk("arst_pass",  {31'd0, pass}, 32'd0);
    @(negedge clk);
    rst = 0;

    // backpressure
    cfg_default();
    aw_stall = 5; w_toggle = 1;
    go(0);
    chk("bp_aw_stalls", aw_stall_cnt, 10);
    chk("bp_w_stalled", {31'd0, (w_stall_cnt > 0)}, 32'd1);
    chk("bp_stable",    stab_err, 0);
    chk("bp_wbad",      count_bad_wdata(), 0);
    chk("bp_wlast",     wlast_mask, 32'h0000_8080);
    chk("bp_aw1",       aw_log[1], 32'h0000_0020);
    chk("bp_pass",      {31'd0, pass}, 32'd1);

    // bad write response on burst 0
    cfg_default();
    bad_b_burst = 0;
    go(0);
    chk("bresp_err",   {16'd0, err_count}, 32'd1);
    chk("bresp_first", first_err, 32'd0);
    chk("bresp_pass",  {31'd0, pass}, 32'd0);

    // bad write response plus early rlast on burst 1 beat 5
    cfg_default();
    bad_b_burst = 0; early_rlast_burst = 1;
    go(0);
    chk("rlast_err",   {16'd0, err_count}, 32'd2);
    chk("rlast_first", first_err, 32'd0);

    // start pulse while busy is ignored
    cfg_default();
    start_pulse_cyc = 10;
    go(0);
    chk("busy_start_naw", n_aw, 2);
    chk("busy_start_nw",  n_w, 16);
    chk("busy_start_err", {16'd0, err_count}, 32'd0);
    chk("busy_start_pass", {31'd0, pass}, 32'd1);

    // reset during WR_DATA
    cfg_default();
    go(3);
    chk("mid_in_wdata", {31'd0, axi.wvalid}, 32'd1);
    #2 rst = 1;
    #1;
    chk("mid_rst_wvalid", {31'd0, axi.wvalid}, 32'd0);
    chk("mid_rst_busy",   {31'd0, busy}, 32'd0);
    chk("mid_rst_wdata",  axi.wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 0;
    clear_inputs();
    axi.awready = 1; axi.wready = 1; axi.arready = 1;
    repeat (4) @(negedge clk);
    chk("post_rst_quiet", {28'd0, axi.awvalid, axi.wvalid, axi.arvalid, busy}, 32'd0);
    clear_inputs();
    go(0);
    chk("restart_pass", {31'd0, pass}, 32'd1);
    chk("restart_nw",   n_w, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
